led_reg_cnt: RTL and testbench



---
 rtl/led_reg_pkg.sv | 39 +++
 rtl/led_reg_bit.sv | 50 +++++
 rtl/led_res_0603.sv | 11 +
 rtl/led_reg_cnt.sv | 68 ++++++
 tb/tb_led_reg_cnt.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/led_reg_pkg.sv
// Shared definitions for the led_reg_cnt register/counter family.
package led_reg_pkg;

  // Operating modes selected by mode_i.
  typedef enum logic [1:0] {
    HOLD  = 2'b00,
    LOAD  = 2'b01,
    SHIFT = 2'b10,
    COUNT = 2'b11
  } mode_e;

  // Widest register the family supports.
  localparam int MAX_WIDTH = 32;

  // True when the register advances as a counter this cycle (not frozen, COUNT selected).
  function automatic logic count_active(input logic dis, input mode_e mode);
    return (~dis) & (mode == COUNT);
  endfunction

  // Next value of one bit for a given mode, before the disable override.
  function automatic logic bit_next(
    input mode_e mode,
    input logic  cur,
    input logic  load_val,
    input logic  shift_in,
    input logic  sum_val
  );
    logic v;
    case (mode)
      HOLD:    v = cur;
      LOAD:    v = load_val;
      SHIFT:   v = shift_in;
      COUNT:   v = sum_val;
      default: v = cur;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/led_reg_bit.sv
// One register bit: 4:1 next-value select, disable bypass, asynchronously
// clearable flip-flop with its own reset value, and an optional LED.
module led_reg_bit
  import led_reg_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0,
  parameter bit   LED_EN    = 1'b1
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  dis_i,
  input  mode_e mode_i,
  input  logic  d_i,
  input  logic  shin_i,
  input  logic  sum_i,
  output logic  q_o
);

  logic r_q;
  logic w_next;

  // Select the next bit value; a disabled register always keeps its value.
  always_comb begin
    w_next = r_q;
    if (dis_i) begin
      w_next = r_q;
    end else begin
      w_next = bit_next(mode_i, r_q, d_i, shin_i, sum_i);
    end
  end

  // State flip-flop, cleared asynchronously to this bit's reset value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q <= RESET_BIT;
    end else begin
      r_q <= w_next;
    end
  end

  // The output is the flop itself, with no logic after it.
  assign q_o = r_q;

  if (LED_EN) begin : g_led
    Led_Res_0603 u_led (
      .anode_i(r_q)
    );
  end

endmodule

// File: rtl/led_res_0603.sv
// Behavioural stand-in for the on-board LED + series resistor footprint.
// It is a passive load: the anode pin is observed but nothing is driven back.
module Led_Res_0603 (
  input logic anode_i
);

  logic w_unused_anode;

  assign w_unused_anode = anode_i;

endmodule

// File: rtl/led_reg_cnt.sv
// WIDTH-bit status register / shift chain / event counter with disable,
// built from led_reg_bit slices. The incrementer and terminal-count
// logic live here so tc_o can cascade into the next stage's dis_i.
module led_reg_cnt
  import led_reg_pkg::*;
#(
  parameter int                   WIDTH     = 8,
  parameter logic [MAX_WIDTH-1:0] RESET_VAL = '0,
  parameter bit                   LED_EN    = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             dis_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] q_o,
  output logic             ser_o,
  output logic             tc_o
);

  if ((WIDTH < 1) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
    $error("led_reg_cnt: WIDTH=%0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end

  mode_e            w_mode;
  logic [WIDTH-1:0] w_carry;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_shin;

  assign w_mode = mode_e'(mode_i);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    // Carry into bit i of q+1 is the AND of all lower bits; bit 0 always
    // receives the +1. Written as a prefix AND so no signal feeds itself.
    if (i == 0) begin : g_lsb
      assign w_carry[i] = 1'b1;
      assign w_shin[i]  = ser_i;
    end else begin : g_upper
      assign w_carry[i] = &q_o[i-1:0];
      assign w_shin[i]  = q_o[i-1];
    end

    assign w_sum[i] = q_o[i] ^ w_carry[i];

    led_reg_bit #(
      .RESET_BIT(RESET_VAL[i]),
      .LED_EN   (LED_EN)
    ) u_bit (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .dis_i (dis_i),
      .mode_i(w_mode),
      .d_i   (d_i[i]),
      .shin_i(w_shin[i]),
      .sum_i (w_sum[i]),
      .q_o   (q_o[i])
    );
  end

  // Shift-chain output is the MSB, visible before the edge that shifts it out.
  assign ser_o = q_o[WIDTH-1];

  // Terminal count is combinational so a following stage can use it as enable
  // in the same cycle, keeping cascaded counters synchronous.
  assign tc_o = (&q_o) & count_active(dis_i, w_mode);

endmodule

// File: tb/tb_led_reg_cnt.sv
// Scoreboard bench for led_reg_cnt: an 8-bit instance (reset value A5),
// a 1-bit instance, and a two-stage 4-bit cascade all share one stimulus stream.
module tb_led_reg_cnt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dis = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] d = 8'h00;
  logic       ser = 1'b0;
  logic       cas_run = 1'b0;

  logic [7:0] q8;
  logic       ser8, tc8;
  logic [0:0] q1;
  logic       ser1, tc1;
  logic [3:0] lo_q, hi_q;
  logic       lo_ser, lo_tc, hi_ser, hi_tc;

  typedef struct {
    logic [7:0] q8;
    logic       tc8;
    logic       ser8;
    logic [7:0] cas;
    logic       q1;
    logic       tc1;
    logic       ser1;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   m8, m1, mcas;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  led_reg_cnt #(.WIDTH(8), .RESET_VAL(32'h0000_00A5), .LED_EN(1'b1)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .dis_i(dis), .mode_i(mode), .d_i(d),
    .ser_i(ser), .q_o(q8), .ser_o(ser8), .tc_o(tc8)
  );

  led_reg_cnt #(.WIDTH(1), .RESET_VAL(32'h0), .LED_EN(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .dis_i(dis), .mode_i(mode), .d_i(d[0:0]),
    .ser_i(ser), .q_o(q1), .ser_o(ser1), .tc_o(tc1)
  );

  led_reg_cnt #(.WIDTH(4), .RESET_VAL(32'h0), .LED_EN(1'b1)) u_cas_lo (
    .clk_i(clk), .rst_i(rst), .dis_i(~cas_run), .mode_i(2'b11), .d_i(4'h0),
    .ser_i(1'b0), .q_o(lo_q), .ser_o(lo_ser), .tc_o(lo_tc)
  );

  led_reg_cnt #(.WIDTH(4), .RESET_VAL(32'h0), .LED_EN(1'b1)) u_cas_hi (
    .clk_i(clk), .rst_i(rst), .dis_i(~lo_tc), .mode_i(2'b11), .d_i(4'h0),
    .ser_i(1'b0), .q_o(hi_q), .ser_o(hi_ser), .tc_o(hi_tc)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of stimulus just after a rising edge, record what the
  // DUTs must show during this cycle, then advance the reference model.
  task automatic step(input logic r, input logic dz, input logic [1:0] md,
                      input logic [7:0] dd, input logic s, input logic run);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; dis = dz; mode = md; d = dd; ser = s; cas_run = run;
    if (r) begin
      m8 = 32'hA5; m1 = 0; mcas = 0;
    end
    e.q8   = m8[7:0];
    e.tc8  = (m8 == 255) && !dz && (md == 2'd3);
    e.ser8 = (m8 >= 128);
    e.cas  = mcas[7:0];
    e.q1   = m1[0];
    e.tc1  = (m1 == 1) && !dz && (md == 2'd3);
    e.ser1 = m1[0];
    sb.push_back(e);
    if (!r) begin
      if (!dz) begin
        case (md)
          2'd1: begin m8 = int'(dd); m1 = int'(dd[0]); end
          2'd2: begin m8 = (m8 * 2 + int'(s)) % 256; m1 = int'(s); end
          2'd3: begin m8 = (m8 + 1) % 256; m1 = (m1 + 1) % 2; end
          default: ;
        endcase
      end
      if (run) mcas = (mcas + 1) % 256;
    end
  endtask

  // Monitor: every falling edge, compare DUT outputs with the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      me = sb.pop_front();
      check("q8",  {24'h0, q8},  {24'h0, me.q8});
      check("tc8", {31'h0, tc8}, {31'h0, me.tc8});
      check("ser8", {31'h0, ser8}, {31'h0, me.ser8});
      check("cascade", {24'h0, hi_q, lo_q}, {24'h0, me.cas});
      check("q1",  {31'h0, q1},  {31'h0, me.q1});
      check("tc1", {31'h0, tc1}, {31'h0, me.tc1});
      check("ser1", {31'h0, ser1}, {31'h0, me.ser1});
    end
  end

  initial begin
    m8 = 32'hA5; m1 = 0; mcas = 0;
    // Reset asserted away from an edge, then released and held.
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    // Load, then disabled load must not change the value.
    step(1'b0, 1'b0, 2'd1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd1, 8'hFF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    // Shift 81 with ser 0,1,1.
    step(1'b0, 1'b0, 2'd1, 8'h81, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd2, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd2, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'd2, 8'h00, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    // Count through wrap, with a disabled cycle parked at all ones.
    step(1'b0, 1'b0, 2'd1, 8'hFE, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd3, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd3, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    // Cascade: 20 counting edges from zero.
    step(1'b1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    #1;
    check("cascade_20", {24'h0, hi_q, lo_q}, 32'h14);
    // Randomised traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("sb_drained", sb.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
